// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline's MEM stage: access sizes, FSM states, default bus timeout.
package pipe_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int DEF_TIMEOUT_CYCLES = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } mem_state_t;

  // Size 2'b11 behaves as a word access everywhere.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lo[0];
      default: bad = (lo != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data formatter: picks the byte/half lane from a little-endian word and sign/zero extends it.
module mem_load_align
  import pipe_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        sext,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension.
  always_comb begin
    byte_s = 8'h00;
    half_s = 16'h0000;
    data   = 32'h0000_0000;
    case (addr)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (addr[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (size)
      SZ_BYTE: data = {{24{sext & byte_s[7]}}, byte_s};
      SZ_HALF: data = {{16{sext & half_s[15]}}, half_s};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs loads/stores over a req/ack data bus with timeout, stalls the pipe meanwhile.
// Optional build macro MEM_ALIGN_CHECK_EN adds misalignment trapping and the mem_alignerr port.
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_b,
  input  logic        ex_m2reg,
  input  logic        ex_wmem,
  input  logic        ex_wreg,
  input  logic [4:0]  ex_rn,
  input  logic [1:0]  ex_size,
  input  logic        ex_sext,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic [31:0] mem_result,
  output logic [31:0] mem_mo,
  output logic        mem_m2reg,
  output logic        mem_wreg,
  output logic [4:0]  mem_rn,
  output logic        mem_stall,
  output logic        mem_buserr
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic        mem_alignerr
`endif
);

  mem_state_t  state_r;
  mem_state_t  state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [31:0] load_buf_r;
  logic        aborted_r;
  logic        acc_s;
  logic        misalign_s;
  logic        ack_hit_s;
  logic        timeout_s;
  logic [3:0]  store_be_s;
  logic [31:0] store_wdata_s;
  logic [31:0] fmt_s;

  assign acc_s     = ex_m2reg | ex_wmem;
  assign ack_hit_s = dm_req & dm_ack;
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign_s = is_misaligned(ex_size, ex_alu[1:0]);
`else
  assign misalign_s = 1'b0;
`endif

  assign mem_result = ex_alu;
  assign mem_m2reg  = ex_m2reg;
  assign mem_rn     = ex_rn;

  mem_load_align u_align (
    .rdata (load_buf_r),
    .addr  (ex_alu[1:0]),
    .size  (ex_size),
    .sext  (ex_sext),
    .data  (fmt_s)
  );

  // Little-endian store lane enables and replicated write data.
  always_comb begin
    store_be_s    = 4'b1111;
    store_wdata_s = ex_b;
    case (ex_size)
      SZ_BYTE: begin
        store_be_s    = 4'b0001 << ex_alu[1:0];
        store_wdata_s = {4{ex_b[7:0]}};
      end
      SZ_HALF: begin
        store_be_s    = ex_alu[1] ? 4'b1100 : 4'b0011;
        store_wdata_s = {2{ex_b[15:0]}};
      end
      default: begin
        store_be_s    = 4'b1111;
        store_wdata_s = ex_b;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; ack wins over timeout on the last allowed cycle.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (acc_s) begin
          state_nxt_s = misalign_s ? ST_DONE : ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (ack_hit_s || timeout_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pipeline-facing outputs; reset forces the stall low even with a pending access.
  always_comb begin
    mem_stall = 1'b0;
    mem_wreg  = 1'b0;
    mem_mo    = 32'h0000_0000;
    case (state_r)
      ST_IDLE:   mem_stall = clrn & acc_s;
      ST_ACCESS: mem_stall = clrn;
      ST_DONE:   mem_stall = 1'b0;
      default:   mem_stall = 1'b0;
    endcase
    if ((state_r == ST_DONE) && acc_s) begin
      mem_mo = fmt_s;
    end else begin
      mem_mo = 32'h0000_0000;
    end
    mem_wreg = ex_wreg & ~mem_stall & ~((state_r == ST_DONE) & aborted_r);
  end

  // Bus registers, timeout counter, load buffer and error pulses.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= 32'h0000_0000;
      dm_be      <= 4'b0000;
      dm_wdata   <= 32'h0000_0000;
      cnt_r      <= '0;
      load_buf_r <= 32'h0000_0000;
      aborted_r  <= 1'b0;
      mem_buserr <= 1'b0;
    end else begin
      mem_buserr <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= '0;
          if (acc_s && misalign_s) begin
            dm_req     <= 1'b0;
            aborted_r  <= 1'b1;
            load_buf_r <= 32'h0000_0000;
          end else if (acc_s) begin
            dm_req    <= 1'b1;
            dm_we     <= ex_wmem;
            dm_addr   <= {ex_alu[31:2], 2'b00};
            dm_be     <= ex_m2reg ? 4'b1111 : store_be_s;
            dm_wdata  <= store_wdata_s;
            aborted_r <= 1'b0;
          end else begin
            dm_req <= 1'b0;
          end
        end
        ST_ACCESS: begin
          if (ack_hit_s) begin
            dm_req     <= 1'b0;
            load_buf_r <= dm_rdata;
            cnt_r      <= '0;
          end else if (timeout_s) begin
            dm_req     <= 1'b0;
            load_buf_r <= 32'h0000_0000;
            aborted_r  <= 1'b1;
            mem_buserr <= 1'b1;
            cnt_r      <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          aborted_r <= 1'b0;
          cnt_r     <= '0;
        end
        default: begin
          dm_req <= 1'b0;
          cnt_r  <= '0;
        end
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // One-cycle alignment fault pulse, high during the DONE cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      mem_alignerr <= 1'b0;
    end else begin
      mem_alignerr <= (state_r == ST_IDLE) & acc_s & misalign_s;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed table, timeout/reset/ack-ignore sequences, random loads/stores.
module tb_mem_access_stage;

  localparam int TMO = 16;

  logic        clk;
  logic        clrn;
  logic [31:0] ex_alu, ex_b;
  logic        ex_m2reg, ex_wmem, ex_wreg;
  logic [4:0]  ex_rn;
  logic [1:0]  ex_size;
  logic        ex_sext;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic [31:0] mem_result, mem_mo;
  logic        mem_m2reg, mem_wreg;
  logic [4:0]  mem_rn;
  logic        mem_stall, mem_buserr;
`ifdef MEM_ALIGN_CHECK_EN
  logic        mem_alignerr;
`endif

  int errors = 0;
  int checks = 0;

  mem_access_stage dut (
    .clk(clk), .clrn(clrn),
    .ex_alu(ex_alu), .ex_b(ex_b), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .ex_wreg(ex_wreg), .ex_rn(ex_rn), .ex_size(ex_size), .ex_sext(ex_sext),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_be(dm_be),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_result(mem_result), .mem_mo(mem_mo), .mem_m2reg(mem_m2reg),
    .mem_wreg(mem_wreg), .mem_rn(mem_rn), .mem_stall(mem_stall),
    .mem_buserr(mem_buserr)
`ifdef MEM_ALIGN_CHECK_EN
    , .mem_alignerr(mem_alignerr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] alu;
    logic [31:0] b;
    logic        m2reg;
    logic        wmem;
    logic        wreg;
    logic [1:0]  size;
    logic        sext;
    int          ack_dly;
    logic [31:0] rdata;
    logic [31:0] exp_mo;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: byte lanes by shifting the little-endian word, extension by arithmetic.
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [1:0] a,
                                         input logic [1:0] sz, input logic sx);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (rd >> (8 * a)) & 32'h0000_00FF;
      if (sx && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (rd >> (16 * a[1])) & 32'h0000_FFFF;
      if (sx && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a, input logic ld);
    if (ld) return 4'hF;
    if (sz == 2'd0) return 4'(1 << a);
    if (sz == 2'd1) return a[1] ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] b);
    if (sz == 2'd0) return b[7:0] * 32'h0101_0101;
    if (sz == 2'd1) return b[15:0] * 32'h0001_0001;
    return b;
  endfunction

  task automatic set_nop(input logic [31:0] alu, input logic wreg);
    ex_alu = alu; ex_b = 32'h0; ex_m2reg = 1'b0; ex_wmem = 1'b0; ex_wreg = wreg;
    ex_rn = 5'd3; ex_size = 2'd2; ex_sext = 1'b0;
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    int exp_req, exp_stall, stall_n, req_n;
    logic timed, done, wreg_bad, first;
    timed     = (v.ack_dly >= TMO);
    exp_req   = timed ? TMO : v.ack_dly + 1;
    exp_stall = exp_req + 1;
    stall_n = 0; req_n = 0; done = 1'b0; wreg_bad = 1'b0; first = 1'b1;
    @(negedge clk);
    ex_alu = v.alu; ex_b = v.b; ex_m2reg = v.m2reg; ex_wmem = v.wmem; ex_wreg = v.wreg;
    ex_rn = 5'd17; ex_size = v.size; ex_sext = v.sext; dm_ack = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (mem_stall) begin
        stall_n++;
        if (mem_wreg) wreg_bad = 1'b1;
        if (dm_req) begin
          if (first) begin
            chk({nm, "_addr"}, dm_addr, {v.alu[31:2], 2'b00});
            chk({nm, "_be"}, {28'h0, dm_be}, {28'h0, v.exp_be});
            chk({nm, "_we"}, {31'h0, dm_we}, {31'h0, v.wmem});
            if (v.wmem) chk({nm, "_wdata"}, dm_wdata, v.exp_wdata);
            first = 1'b0;
          end
          if (req_n == v.ack_dly) begin
            dm_ack = 1'b1; dm_rdata = v.rdata;
          end else begin
            dm_ack = 1'b0; dm_rdata = $urandom;
          end
          req_n++;
        end else begin
          dm_ack = 1'b0;
        end
        @(negedge clk);
      end else begin
        done = 1'b1;
      end
    end
    dm_ack = 1'b0;
    chk({nm, "_finished"}, {31'h0, done}, 32'd1);
    chk({nm, "_stalls"}, stall_n, exp_stall);
    chk({nm, "_reqcycles"}, req_n, exp_req);
    chk({nm, "_wreg_stalled"}, {31'h0, wreg_bad}, 32'd0);
    chk({nm, "_done_req"}, {31'h0, dm_req}, 32'd0);
    chk({nm, "_done_wreg"}, {31'h0, mem_wreg}, {31'h0, v.wreg & ~timed});
    chk({nm, "_done_buserr"}, {31'h0, mem_buserr}, {31'h0, timed});
    chk({nm, "_result"}, mem_result, v.alu);
    chk({nm, "_rn"}, {27'h0, mem_rn}, 32'd17);
    if (v.m2reg) chk({nm, "_mo"}, mem_mo, v.exp_mo);
    @(negedge clk);
    set_nop(32'h0BAD_0000 ^ v.alu, 1'b1);
    #1;
    chk({nm, "_nop_stall"}, {31'h0, mem_stall}, 32'd0);
    chk({nm, "_nop_wreg"}, {31'h0, mem_wreg}, 32'd1);
    chk({nm, "_nop_mo"}, mem_mo, 32'd0);
    chk({nm, "_nop_buserr"}, {31'h0, mem_buserr}, 32'd0);
  endtask

  initial begin
    vec_t rv;
    logic [1:0] sz;
    logic ld;
    bit got;
    vecs[0] = '{32'h100, 32'h0,         1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 4'hF, 32'h0};
    vecs[1] = '{32'h103, 32'h0,         1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 0,  32'h80FF0011, 32'hFFFFFF80, 4'hF, 32'h0};
    vecs[2] = '{32'h103, 32'h0,         1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 0,  32'h80FF0011, 32'h00000080, 4'hF, 32'h0};
    vecs[3] = '{32'h202, 32'h1234ABCD,  1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 0,  32'h0,        32'h0,        4'hC, 32'hABCDABCD};
    vecs[4] = '{32'h102, 32'h0,         1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 2,  32'h80017FFF, 32'hFFFF8001, 4'hF, 32'h0};
    vecs[5] = '{32'h301, 32'h000000A5,  1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1,  32'h0,        32'h0,        4'h2, 32'hA5A5A5A5};
    vecs[6] = '{32'h400, 32'hCAFEF00D,  1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 3,  32'h0,        32'h0,        4'hF, 32'hCAFEF00D};
    vecs[7] = '{32'h100, 32'h0,         1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 0,  32'h1234F00D, 32'h0000F00D, 4'hF, 32'h0};
    vecs[8] = '{32'h500, 32'h0,         1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 20, 32'h12345678, 32'h0,        4'hF, 32'h0};
    vecs[9] = '{32'h504, 32'h0,         1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 15, 32'h11223344, 32'h11223344, 4'hF, 32'h0};

    clrn = 1'b0; dm_ack = 1'b0; dm_rdata = 32'h0;
    set_nop(32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", {31'h0, dm_req}, 32'd0);
    chk("rst_we", {31'h0, dm_we}, 32'd0);
    chk("rst_be", {28'h0, dm_be}, 32'd0);
    chk("rst_addr", dm_addr, 32'd0);
    chk("rst_wdata", dm_wdata, 32'd0);
    chk("rst_stall", {31'h0, mem_stall}, 32'd0);
    chk("rst_buserr", {31'h0, mem_buserr}, 32'd0);
    @(negedge clk);
    clrn = 1'b1;

    for (int i = 0; i < 10; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Ack while no request is outstanding must not disturb an idle stage.
    @(negedge clk);
    set_nop(32'h77, 1'b1);
    dm_ack = 1'b1; dm_rdata = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge clk); #1;
      chk("stray_ack_stall", {31'h0, mem_stall}, 32'd0);
      chk("stray_ack_req", {31'h0, dm_req}, 32'd0);
      chk("stray_ack_mo", mem_mo, 32'd0);
    end
    dm_ack = 1'b0;
    run_txn(vecs[0], "after_stray");

    // Reset asserted mid-access abandons the transfer.
    @(negedge clk);
    ex_alu = 32'h600; ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_size = 2'd2;
    got = 1'b0;
    for (int c = 0; c < 5 && !got; c++) begin
      @(negedge clk); #1;
      if (dm_req) got = 1'b1;
    end
    chk("midrst_reached_access", {31'h0, got}, 32'd1);
    clrn = 1'b0;
    #1;
    chk("midrst_req", {31'h0, dm_req}, 32'd0);
    chk("midrst_stall", {31'h0, mem_stall}, 32'd0);
    chk("midrst_be", {28'h0, dm_be}, 32'd0);
    @(negedge clk);
    set_nop(32'h1234, 1'b1);
    clrn = 1'b1;
    #1;
    chk("postrst_stall", {31'h0, mem_stall}, 32'd0);
    chk("postrst_wreg", {31'h0, mem_wreg}, 32'd1);
    chk("postrst_result", mem_result, 32'h1234);
    @(negedge clk); #1;
    chk("postrst_stall2", {31'h0, mem_stall}, 32'd0);
    chk("postrst_req2", {31'h0, dm_req}, 32'd0);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word load traps without touching the bus.
    @(negedge clk);
    ex_alu = 32'h101; ex_m2reg = 1'b1; ex_wmem = 1'b0; ex_wreg = 1'b1; ex_size = 2'd2;
    #1;
    chk("align_stall", {31'h0, mem_stall}, 32'd1);
    chk("align_req0", {31'h0, dm_req}, 32'd0);
    @(negedge clk); #1;
    chk("align_done_stall", {31'h0, mem_stall}, 32'd0);
    chk("align_done_req", {31'h0, dm_req}, 32'd0);
    chk("align_pulse", {31'h0, mem_alignerr}, 32'd1);
    chk("align_wreg", {31'h0, mem_wreg}, 32'd0);
    @(negedge clk);
    set_nop(32'h0, 1'b1);
    #1;
    chk("align_pulse_end", {31'h0, mem_alignerr}, 32'd0);
`endif

    // Random loads and stores against the reference functions.
    for (int n = 0; n < 150; n++) begin
      sz = 2'($urandom_range(0, 3));
      ld = 1'($urandom_range(0, 1));
      rv.alu = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      if (sz == 2'd1) rv.alu[0] = 1'b0;
      if (sz[1]) rv.alu[1:0] = 2'b00;
`endif
      rv.b = $urandom;
      rv.m2reg = ld;
      rv.wmem = ~ld;
      rv.wreg = ld;
      rv.size = sz;
      rv.sext = 1'($urandom_range(0, 1));
      rv.ack_dly = ($urandom_range(0, 9) == 0) ? 16 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 5));
      rv.rdata = $urandom;
      rv.exp_mo = (rv.ack_dly >= TMO) ? 32'h0 : m_load(rv.rdata, rv.alu[1:0], sz, rv.sext);
      rv.exp_be = m_be(sz, rv.alu[1:0], ld);
      rv.exp_wdata = m_wdata(sz, rv.b);
      run_txn(rv, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage of the 5-stage CPU. It sits between the EX/MEM register and the MEM/WB register.
- It runs each load/store against the data-memory bus with a req/ack handshake, stalling the pipeline until the access completes.
- It formats load data (byte/half/word, sign/zero extension) and drives the mem_result/mem_mo/mem_m2reg/mem_wreg/mem_rn inputs of MEM/WB.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles in ACCESS waiting for dm_ack before bus-error abort.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- clrn  in  1  asynchronous active-low reset.
- ex_alu  in  32  ALU result / effective address from EX/MEM.
- ex_b  in  32  store data from EX/MEM.
- ex_m2reg  in  1  load instruction (result comes from memory).
- ex_wmem  in  1  store instruction.
- ex_wreg  in  1  instruction writes the register file.
- ex_rn  in  5  destination register number.
- ex_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word.
- ex_sext  in  1  sign-extend sub-word loads; 0 means zero-extend.
- dm_req  out  1  bus request, registered.
- dm_we  out  1  write enable, valid with dm_req.
- dm_addr  out  32  word-aligned address ({ex_alu[31:2],2'b00}).
- dm_be  out  4  byte enables.
- dm_wdata  out  32  lane-replicated store data.
- dm_ack  in  1  bus completion, sampled while dm_req=1.
- dm_rdata  in  32  read data, valid with dm_ack.
- mem_result  out  32  ex_alu passed through.
- mem_mo  out  32  formatted load data.
- mem_m2reg  out  1  ex_m2reg passed through.
- mem_wreg  out  1  gated write enable.
- mem_rn  out  5  ex_rn passed through.
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM.
- mem_buserr  out  1  one-cycle pulse on timeout.

Behaviour:
- FSM states: IDLE, ACCESS, DONE. Let acc = ex_m2reg | ex_wmem.
- IDLE:
  - acc=0: no stall; outputs pass through; dm_req=0.
  - acc=1: mem_stall=1; the dm_we/dm_be/dm_wdata/dm_addr registers are loaded; next state ACCESS.
- ACCESS:
  - dm_req=1, mem_stall=1; timeout counter increments each cycle.
  - dm_ack=1: capture dm_rdata into a load buffer; dm_req drops the next cycle; next state DONE.
  - Counter reaches TIMEOUT_CYCLES without ack: mem_buserr pulses; load buffer is cleared to 0; mem_wreg is suppressed in DONE; next state DONE.
- DONE:
  - mem_stall=0 and mem_mo = formatted buffer. The pipeline advances this cycle.
  - Next state is always IDLE; a back-to-back access is re-detected in IDLE.
- Minimum access cost: 2 stall cycles (ack in the first ACCESS cycle).
- mem_wreg = ex_wreg & ~mem_stall & ~(aborted). This inserts a bubble into MEM/WB while stalled.
- mem_result, mem_m2reg and mem_rn are combinational pass-throughs. EX/MEM holds its inputs stable while stalled.
- Store lanes (little-endian):
  - byte: dm_be = 1<<ex_alu[1:0]; dm_wdata = {4{ex_b[7:0]}}.
  - half: dm_be = ex_alu[1] ? 1100 : 0011; dm_wdata = {2{ex_b[15:0]}}.
  - word: dm_be = 1111; dm_wdata = ex_b.
- Loads: dm_we=0 and dm_be=1111. The lane is selected by ex_alu[1:0] (byte) or ex_alu[1] (half), then sign- or zero-extended per ex_sext.
- dm_ack while dm_req=0 is ignored.
- Reset (clrn=0), including mid-access:
  - state=IDLE; counter=0; buffer=0.
  - dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0.
  - mem_buserr=0, mem_stall=0.
  - The in-flight access is abandoned. The bus must tolerate an unmatched request.
- When acc=0, mem_mo = 0.

Optional Feature:
- MEM_ALIGN_CHECK_EN defined:
  - A misaligned half (ex_alu[0]=1) or word (ex_alu[1:0]!=0) access in IDLE issues no bus request.
  - The FSM goes directly to DONE (1 stall cycle); new output mem_alignerr pulses; mem_wreg is suppressed.
  - A store performs no write.
- Undefined: no check. The low address bits are ignored for word accesses, and ex_alu[0] is ignored for half accesses. Port mem_alignerr is absent.

Decomposition:
- Shared package pipe_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD, FSM state encoding, default TIMEOUT_CYCLES constant.
- One sub-module, mem_load_align: combinational lane extraction plus sign/zero extension (inputs: rdata, addr[1:0], size, sext).
- Store lane generation stays inline.

Test Plan:
- Word load, ex_alu=0x100, dm_ack in first ACCESS cycle, dm_rdata=0xDEADBEEF -> dm_addr=0x100, mem_stall high exactly 2 cycles, mem_mo=0xDEADBEEF in DONE with mem_wreg=1.
- Byte load, ex_alu=0x103, sext=1, rdata=0x80FF0011 -> mem_mo=0xFFFFFF80; with sext=0 -> 0x00000080.
- Half store, ex_alu=0x202, ex_b=0x1234ABCD -> dm_we=1, dm_be=1100, dm_wdata=0xABCDABCD; mem_wreg=0 throughout.
- No ack, TIMEOUT_CYCLES=16 -> dm_req high 16 cycles, mem_buserr one-cycle pulse, mem_mo=0, mem_wreg=0, FSM returns to IDLE.
- clrn pulsed low during ACCESS -> dm_req and mem_stall drop immediately; the following ALU instruction (acc=0) passes with zero stall.
- MEM_ALIGN_CHECK_EN: word load at 0x101 -> no dm_req, 1 stall cycle, mem_alignerr pulse, mem_wreg=0.
